// File: rtl/ordering_reader.sv
// ordering_reader: fetches one replica's city ordering and streams it to the host as LANES-wide beats.
// Defining ORDERING_PERM_CHECK_EN adds a seen-bitmap permutation check that drives perm_error.
module ordering_reader #(
    parameter int  NCITY    = 31,
    parameter int  NREPLICA = 32,
    parameter int  LANES    = 8,
    parameter int  CW       = 8,
    localparam int RW       = (NREPLICA > 1) ? $clog2(NREPLICA) : 1,
    localparam int AW       = (NCITY > 1) ? $clog2(NCITY) : 1,
    localparam int LW       = $clog2(LANES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [RW-1:0]       replica_sel,
    output logic                busy,
    output logic                mem_re,
    output logic [RW-1:0]       mem_replica,
    output logic [AW-1:0]       mem_addr,
    input  logic [CW-1:0]       mem_rdata,
    input  logic                ordering_read,
    output logic                ordering_ready,
    output logic [LANES*CW-1:0] ordering_rdata,
    output logic                ordering_last,
    output logic [LW-1:0]       ordering_lanes,
    output logic                perm_error
);

    localparam int PW  = $clog2(NCITY + 1);
    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT
    } state_t;

    state_t                   state;
    state_t                   next_state;

    logic [PW-1:0]            pos;
    logic [PW-1:0]            base_pos;
    logic [LW-1:0]            cnt;
    logic [LW-1:0]            beat_n;
    logic [LW-1:0]            n_next;
    logic                     beat_last;
    logic [LANES-1:0][CW-1:0] beat;
    logic [RW-1:0]            replica_q;
    logic                     rd_valid_q;
    logic [LIW-1:0]           rd_lane_q;
    int                       remaining;

    logic                     accept;
    logic                     xfer;
    logic                     begin_beat;
    logic                     finish;

    assign accept     = (state == IDLE) && start;
    assign xfer       = (state == PRESENT) && ordering_read;
    assign begin_beat = accept || (xfer && !beat_last);
    assign finish     = xfer && beat_last;

    // Size of the beat about to be fetched: a full beat, or whatever cities remain.
    always_comb begin
        base_pos  = accept ? '0 : pos;
        remaining = NCITY - int'(base_pos);
        n_next    = (remaining > LANES) ? LW'(LANES) : LW'(remaining);
    end

    always_ff @(posedge clk) begin
        // NOTE: flops use <= so every register samples values from before the edge.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   if (cnt == beat_n - LW'(1)) next_state = WAIT;
            WAIT:    next_state = PRESENT;
            PRESENT: if (ordering_read) next_state = beat_last ? IDLE : FETCH;
            default: next_state = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign mem_re         = (state == FETCH);
    assign ordering_ready = (state == PRESENT);
    assign mem_addr       = AW'(pos);
    assign mem_replica    = replica_q;
    assign ordering_rdata = beat;
    assign ordering_last  = beat_last;
    assign ordering_lanes = beat_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the beat register is reset because its idle value is visible on ordering_rdata.
            pos        <= '0;
            cnt        <= '0;
            beat_n     <= '0;
            beat_last  <= 1'b0;
            beat       <= '0;
            replica_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_lane_q  <= '0;
        end else begin
            // Read data returns one cycle after mem_re, so the target lane travels with it.
            rd_valid_q <= mem_re;
            rd_lane_q  <= LIW'(LANES - 1 - int'(cnt));

            if (accept) replica_q <= replica_sel;

            if (begin_beat) begin
                pos       <= base_pos;
                cnt       <= '0;
                beat_n    <= n_next;
                beat_last <= (int'(base_pos) + int'(n_next) == NCITY);
                beat      <= '0;
            end else if (finish) begin
                pos       <= '0;
                cnt       <= '0;
                beat_n    <= '0;
                beat_last <= 1'b0;
                beat      <= '0;
                replica_q <= '0;
            end else if (state == FETCH) begin
                pos <= pos + PW'(1);
                cnt <= cnt + LW'(1);
            end

            if (rd_valid_q) beat[rd_lane_q] <= mem_rdata;
        end
    end

`ifdef ORDERING_PERM_CHECK_EN
    logic [NCITY-1:0] seen;
    logic             perm_error_q;

    // seen needs no reset of its own: every accepted start clears it before use.
    always_ff @(posedge clk) begin
        if (reset) begin
            perm_error_q <= 1'b0;
        end else if (accept) begin
            seen         <= '0;
            perm_error_q <= 1'b0;
        end else if (rd_valid_q) begin
            if (32'(mem_rdata) >= 32'(NCITY)) begin
                perm_error_q <= 1'b1;
            end else begin
                for (int i = 0; i < NCITY; i++) begin
                    if (32'(mem_rdata) == 32'(i)) begin
                        if (seen[i]) perm_error_q <= 1'b1;
                        seen[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign perm_error = perm_error_q;
`else
    assign perm_error = 1'b0;
`endif

endmodule
